// File: rtl/selecionar_menor_ativo_pkg.sv
// Shared definitions for the active-node classifier and the minimum selector:
// scan FSM state encoding and the packed-array slice helper.
package selecionar_menor_ativo_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSCA   = 2'd1,
    ENTREGA = 2'd2,
    FIM     = 2'd3
  } estado_t;

  // Low bit position of element 'indice' in a flat vector of 'largura'-bit fields.
  function automatic int unsigned base_fatia(input int unsigned indice,
                                             input int unsigned largura);
    return indice * largura;
  endfunction

endpackage

// File: rtl/selecionar_comparador.sv
// Combinational match of node idx: selects its criterion/address from the
// packed arrays and flags it when active and equal to the frozen minimum.
module selecionar_comparador
  import selecionar_menor_ativo_pkg::*;
#(
  parameter int unsigned NUM_NA         = 8,
  parameter int unsigned ADDR_WIDTH     = 8,
  parameter int unsigned CRITERIO_WIDTH = 5,
  parameter int unsigned IDX_WIDTH      = 3
) (
  input  logic [IDX_WIDTH-1:0]             idx,
  input  logic [CRITERIO_WIDTH-1:0]        min_criterio,
  input  logic [NUM_NA-1:0]                na_ativo,
  input  logic [NUM_NA*CRITERIO_WIDTH-1:0] na_criterio,
  input  logic [NUM_NA*ADDR_WIDTH-1:0]     na_endereco,
  output logic                             casa,
  output logic [ADDR_WIDTH-1:0]            endereco,
  output logic [CRITERIO_WIDTH-1:0]        criterio
);

  // Mux out the current node and compare it against the minimum.
  always_comb begin
    criterio = na_criterio[base_fatia(32'(idx), CRITERIO_WIDTH) +: CRITERIO_WIDTH];
    endereco = na_endereco[base_fatia(32'(idx), ADDR_WIDTH) +: ADDR_WIDTH];
    casa     = na_ativo[idx] && (criterio == min_criterio);
  end

endmodule

// File: rtl/selecionar_menor_ativo.sv
// Scans the node array and hands out every active node whose criterion equals
// the classifier's global minimum. Define SELECIONAR_PRIMEIRO_EN to deliver
// only the first (lowest-index) match per scan.
module selecionar_menor_ativo
  import selecionar_menor_ativo_pkg::*;
#(
  parameter int unsigned NUM_NA         = 8,
  parameter int unsigned ADDR_WIDTH     = 8,
  parameter int unsigned CRITERIO_WIDTH = 5
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             sm_iniciar_in,
  input  logic                             ca_pronto_in,
  input  logic [CRITERIO_WIDTH-1:0]        ca_criterio_geral_in,
  input  logic [NUM_NA-1:0]                na_ativo_in,
  input  logic [NUM_NA*CRITERIO_WIDTH-1:0] na_criterio_in,
  input  logic [NUM_NA*ADDR_WIDTH-1:0]     na_endereco_in,
  input  logic                             sm_ready_in,
  output logic                             sm_valid_o,
  output logic [ADDR_WIDTH-1:0]            sm_endereco_o,
  output logic [CRITERIO_WIDTH-1:0]        sm_criterio_o,
  output logic                             sm_fim_o,
  output logic [$clog2(NUM_NA):0]          sm_qtd_o,
  output logic                             sm_ocupado_o
);

  localparam int unsigned IDX_WIDTH = $clog2(NUM_NA);
  localparam int unsigned QTD_WIDTH = $clog2(NUM_NA) + 1;
  localparam logic [IDX_WIDTH-1:0] IDX_MAX = IDX_WIDTH'(NUM_NA - 1);

  estado_t                   estado_r,   estado_s;
  logic [IDX_WIDTH-1:0]      idx_r,      idx_s;
  logic [CRITERIO_WIDTH-1:0] min_r,      min_s;
  logic                      valid_r,    valid_s;
  logic [ADDR_WIDTH-1:0]     endereco_r, endereco_s;
  logic [CRITERIO_WIDTH-1:0] criterio_r, criterio_s;
  logic                      fim_r,      fim_s;
  logic [QTD_WIDTH-1:0]      qtd_r,      qtd_s;
  logic                      ocupado_r,  ocupado_s;

  logic                      casa_s;
  logic [ADDR_WIDTH-1:0]     no_endereco_s;
  logic [CRITERIO_WIDTH-1:0] no_criterio_s;

  selecionar_comparador #(
    .NUM_NA         (NUM_NA),
    .ADDR_WIDTH     (ADDR_WIDTH),
    .CRITERIO_WIDTH (CRITERIO_WIDTH),
    .IDX_WIDTH      (IDX_WIDTH)
  ) u_comparador (
    .idx          (idx_r),
    .min_criterio (min_r),
    .na_ativo     (na_ativo_in),
    .na_criterio  (na_criterio_in),
    .na_endereco  (na_endereco_in),
    .casa         (casa_s),
    .endereco     (no_endereco_s),
    .criterio     (no_criterio_s)
  );

  // State register and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado_r   <= IDLE;
      idx_r      <= '0;
      min_r      <= '0;
      valid_r    <= 1'b0;
      endereco_r <= '0;
      criterio_r <= '0;
      fim_r      <= 1'b0;
      qtd_r      <= '0;
      ocupado_r  <= 1'b0;
    end else begin
      estado_r   <= estado_s;
      idx_r      <= idx_s;
      min_r      <= min_s;
      valid_r    <= valid_s;
      endereco_r <= endereco_s;
      criterio_r <= criterio_s;
      fim_r      <= fim_s;
      qtd_r      <= qtd_s;
      ocupado_r  <= ocupado_s;
    end
  end

  // Next-state and next-output logic of the scan.
  always_comb begin
    estado_s   = estado_r;
    idx_s      = idx_r;
    min_s      = min_r;
    valid_s    = valid_r;
    endereco_s = endereco_r;
    criterio_s = criterio_r;
    qtd_s      = qtd_r;

    case (estado_r)
      IDLE: begin
        if (sm_iniciar_in && ca_pronto_in) begin
          estado_s = BUSCA;
          min_s    = ca_criterio_geral_in;
          idx_s    = '0;
          qtd_s    = '0;
        end else begin
          estado_s = IDLE;
        end
      end
      BUSCA: begin
        if (casa_s) begin
          valid_s    = 1'b1;
          endereco_s = no_endereco_s;
          criterio_s = no_criterio_s;
          estado_s   = ENTREGA;
        end else if (idx_r == IDX_MAX) begin
          estado_s = FIM;
        end else begin
          idx_s = idx_r + IDX_WIDTH'(1);
        end
      end
      ENTREGA: begin
        if (valid_r && sm_ready_in) begin
          valid_s = 1'b0;
          qtd_s   = qtd_r + QTD_WIDTH'(1);
`ifdef SELECIONAR_PRIMEIRO_EN
          estado_s = FIM;
`else
          if (idx_r == IDX_MAX) begin
            estado_s = FIM;
          end else begin
            idx_s    = idx_r + IDX_WIDTH'(1);
            estado_s = BUSCA;
          end
`endif
        end else begin
          estado_s = ENTREGA;
        end
      end
      FIM: begin
        estado_s = IDLE;
      end
      default: begin
        estado_s = IDLE;
        valid_s  = 1'b0;
      end
    endcase

    // Flags are registered versions of the state being entered.
    fim_s     = (estado_s == FIM);
    ocupado_s = (estado_s != IDLE);
  end

  assign sm_valid_o    = valid_r;
  assign sm_endereco_o = endereco_r;
  assign sm_criterio_o = criterio_r;
  assign sm_fim_o      = fim_r;
  assign sm_qtd_o      = qtd_r;
  assign sm_ocupado_o  = ocupado_r;

endmodule
